key_input_conditioner: RTL and testbench

- Conditions the raw, active-low, bouncy DE2 push-buttons (KEY[3] = left, KEY[0] = right) into clean active-high signals for the player movement logic and menu logic.
- Per channel: 2-flop synchroniser, counter-based debouncer, one-cycle press pulse, optional hold-to-repeat pulse train.
- The debounced levels drive the existing left/right movement inputs. The pulses serve edge-driven consumers such as menus and fire.

---
 rtl/key_input_conditioner_if.sv | 28 ++
 rtl/key_input_conditioner.sv | 126 ++++++++++++
 tb/tb_key_input_conditioner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/key_input_conditioner_if.sv
// Push-button bundle: raw active-low keys in, clean levels and one-cycle strobes out.
// The conditioner uses the slave side; the key source or bench uses the master side.
interface key_input_conditioner_if;
    logic key_left_n;
    logic key_right_n;
    logic left;
    logic right;
    logic left_pulse;
    logic right_pulse;

    modport master (
        output key_left_n,
        output key_right_n,
        input  left,
        input  right,
        input  left_pulse,
        input  right_pulse
    );

    modport slave (
        input  key_left_n,
        input  key_right_n,
        output left,
        output right,
        output left_pulse,
        output right_pulse
    );
endinterface

// File: rtl/key_input_conditioner.sv
// Two-channel key conditioner: synchroniser, counter debouncer, press strobe and
// hold-to-repeat strobe train per key. Channel 1 = left (KEY[3]), channel 0 = right (KEY[0]).
module key_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 3125000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned CNT_W           = 28
) (
    input  logic                    clock,
    input  logic                    reset,
    key_input_conditioner_if.slave  keys
);
    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             PH_DELAY  = 1'b0;
    localparam logic             PH_PERIOD = 1'b1;

    logic [1:0] key_n;
    logic [1:0] level;
    logic [1:0] pulse;
    logic       both_held;

    assign key_n     = {keys.key_left_n, keys.key_right_n};
    assign both_held = &level;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             sync1_q;
            logic             s_q;
            state_t           state_q;
            logic [CNT_W-1:0] dcnt_q;
            logic [CNT_W-1:0] rcnt_q;
            logic             rphase_q;
            logic             level_q;
            logic             pulse_q;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    sync1_q  <= 1'b0;
                    s_q      <= 1'b0;
                    state_q  <= RELEASED;
                    dcnt_q   <= '0;
                    rcnt_q   <= '0;
                    rphase_q <= PH_DELAY;
                    level_q  <= 1'b0;
                    pulse_q  <= 1'b0;
                end else begin
                    sync1_q <= ~key_n[gi];
                    s_q     <= sync1_q;
                    pulse_q <= 1'b0;
                    case (state_q)
                        RELEASED: begin
                            if (s_q) begin
                                state_q <= PRESS_PEND;
                                dcnt_q  <= '0;
                            end
                        end
                        PRESS_PEND: begin
                            if (!s_q) begin
                                state_q <= RELEASED;
                            end else if (dcnt_q == DEB_LAST) begin
                                state_q  <= PRESSED;
                                level_q  <= 1'b1;
                                pulse_q  <= 1'b1;
                                rcnt_q   <= '0;
                                rphase_q <= PH_DELAY;
                            end else begin
                                dcnt_q <= dcnt_q + CNT_ONE;
                            end
                        end
                        PRESSED: begin
                            if (!s_q) begin
                                state_q <= RELEASE_PEND;
                                dcnt_q  <= '0;
                            end else if (REPEAT_EN) begin
                                // Counter keeps its schedule even while both keys suppress the strobe.
                                if (rphase_q == PH_DELAY && rcnt_q == DLY_LAST) begin
                                    rcnt_q   <= '0;
                                    rphase_q <= PH_PERIOD;
                                    pulse_q  <= ~both_held;
                                end else if (rphase_q == PH_PERIOD && rcnt_q == PER_LAST) begin
                                    rcnt_q  <= '0;
                                    pulse_q <= ~both_held;
                                end else begin
                                    rcnt_q <= rcnt_q + CNT_ONE;
                                end
                            end
                        end
                        RELEASE_PEND: begin
                            if (s_q) begin
                                state_q <= PRESSED;
                            end else if (dcnt_q == DEB_LAST) begin
                                state_q <= RELEASED;
                                level_q <= 1'b0;
                            end else begin
                                dcnt_q <= dcnt_q + CNT_ONE;
                            end
                        end
                        default: begin
                            state_q <= RELEASED;
                            level_q <= 1'b0;
                        end
                    endcase
                end
            end

            assign level[gi] = level_q;
            assign pulse[gi] = pulse_q;
        end
    endgenerate

    assign keys.left        = level[1];
    assign keys.right       = level[0];
    assign keys.left_pulse  = pulse[1];
    assign keys.right_pulse = pulse[0];
endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with short debounce/repeat constants.
// Outputs are packed as {left, right, left_pulse, right_pulse} for comparison.
module tb_key_input_conditioner;
    localparam int unsigned DEB  = 4;
    localparam int unsigned RDLY = 10;
    localparam int unsigned RPER = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    key_input_conditioner_if kif ();
    key_input_conditioner_if kif_nr ();

    key_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER),
        .REPEAT_EN      (1'b1),
        .CNT_W          (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .keys (kif)
    );

    key_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER),
        .REPEAT_EN      (1'b0),
        .CNT_W          (8)
    ) dut_nr (
        .clock(clock),
        .reset(reset),
        .keys (kif_nr)
    );

    logic [3:0] dut_outs;
    logic [3:0] nr_outs;
    assign dut_outs = {kif.left, kif.right, kif.left_pulse, kif.right_pulse};
    assign nr_outs  = {kif_nr.left, kif_nr.right, kif_nr.left_pulse, kif_nr.right_pulse};

    typedef struct {
        logic       rst;
        logic       ln;
        logic       rn;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add_rows(input int n, input logic rst, input logic ln, input logic rn,
                            input logic [3:0] exp);
        vec_t v;
        v.rst = rst;
        v.ln  = ln;
        v.rn  = rn;
        v.exp = exp;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // Drive at the falling edge, clock one rising edge, return at the next falling edge.
    task automatic step(input logic rst, input logic ln, input logic rn);
        reset              = rst;
        kif.key_left_n     = ln;
        kif.key_right_n    = rn;
        kif_nr.key_left_n  = ln;
        kif_nr.key_right_n = rn;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %0b expected %0b", name, idx, got, exp);
        end else begin
            $display("ok   %s edge %0d: %0b", name, idx, got);
        end
    endtask

    initial begin
        logic [3:0] exp;
        logic [3:0] m;
        int         cnt;

        // Clean press/release, bounce restart, short glitch.
        add_rows(1,  1'b0, 1'b1, 1'b1, 4'b0000);
        add_rows(6,  1'b1, 1'b0, 1'b1, 4'b0000);
        add_rows(1,  1'b1, 1'b0, 1'b1, 4'b1010);
        add_rows(2,  1'b1, 1'b0, 1'b1, 4'b1000);
        add_rows(6,  1'b1, 1'b1, 1'b1, 4'b1000);
        add_rows(3,  1'b1, 1'b1, 1'b1, 4'b0000);
        add_rows(3,  1'b1, 1'b0, 1'b1, 4'b0000);
        add_rows(1,  1'b1, 1'b1, 1'b1, 4'b0000);
        add_rows(6,  1'b1, 1'b0, 1'b1, 4'b0000);
        add_rows(1,  1'b1, 1'b0, 1'b1, 4'b1010);
        add_rows(6,  1'b1, 1'b1, 1'b1, 4'b1000);
        add_rows(1,  1'b1, 1'b1, 1'b1, 4'b0000);
        add_rows(2,  1'b1, 1'b0, 1'b1, 4'b0000);
        add_rows(10, 1'b1, 1'b1, 1'b1, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].ln, tbl[i].rn);
            chk("table", i, 32'(dut_outs), 32'(tbl[i].exp));
        end

        // Auto-repeat on right, then release.
        step(1'b0, 1'b1, 1'b1);
        chk("rep_reset", 0, 32'(dut_outs), 32'(4'b0000));
        for (int e = 1; e <= 30; e++) begin
            step(1'b1, 1'b1, 1'b0);
            exp = {1'b0, (e >= 7), 1'b0,
                   (e == 7 || e == 17 || e == 21 || e == 25 || e == 29)};
            chk("repeat_hold", e, 32'(dut_outs), 32'(exp));
        end
        for (int r = 1; r <= 12; r++) begin
            step(1'b1, 1'b1, 1'b1);
            exp = {1'b0, (r < 7), 1'b0, 1'b0};
            chk("repeat_release", r, 32'(dut_outs), 32'(exp));
        end

        // Both held: press strobes only; then right released, left resumes its schedule.
        step(1'b0, 1'b1, 1'b1);
        chk("conf_reset", 0, 32'(dut_outs), 32'(4'b0000));
        for (int e = 1; e <= 30; e++) begin
            step(1'b1, 1'b0, 1'b0);
            exp = {(e >= 7), (e >= 7), (e == 7), (e == 7)};
            chk("conflict_both", e, 32'(dut_outs), 32'(exp));
        end
        for (int e = 31; e <= 46; e++) begin
            step(1'b1, 1'b0, 1'b1);
            exp = {1'b1, (e < 37), (e == 41 || e == 45), 1'b0};
            // Edge 37 is the cycle the right level drops; the left strobe there is not judged.
            m = (e == 37) ? 4'b1101 : 4'b1111;
            chk("conflict_release", e, 32'(dut_outs & m), 32'(exp & m));
        end

        // Reset while left is repeating; key still held afterwards.
        step(1'b0, 1'b0, 1'b1);
        chk("midrep_reset", 0, 32'(dut_outs), 32'(4'b0000));
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, 1'b1);
            exp = {(k >= 7), 1'b0, (k == 7), 1'b0};
            chk("after_reset", k, 32'(dut_outs), 32'(exp));
        end

        // Repeat disabled: exactly one strobe over a long hold.
        step(1'b0, 1'b1, 1'b1);
        chk("nr_reset", 0, 32'(nr_outs), 32'(4'b0000));
        cnt = 0;
        for (int e = 1; e <= 50; e++) begin
            step(1'b1, 1'b0, 1'b1);
            if (kif_nr.left_pulse === 1'b1) cnt++;
            if (e == 7) chk("nr_press", e, 32'(nr_outs), 32'(4'b1010));
        end
        chk("nr_pulse_count", 50, 32'(cnt), 32'd1);
        chk("nr_level", 50, 32'(nr_outs), 32'(4'b1000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
